fft_frame_loader: RTL and testbench

//  Collects FFT_LEN consecutive samples from the registered ADC sample bus into an internal

---
 rtl/fft_frame_loader.sv | 114 +++++++++++
 tb/tb_fft_frame_loader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_loader.sv
// Captures FFT_LEN ADC samples into a frame RAM, then streams them to the FFT over valid/ready/last.
// Define OFFSET_BIN_CONV_EN to invert the sample MSB on capture (offset-binary -> two's complement).
module fft_frame_loader #(
  parameter int DATA_W   = 16,
  parameter int LEN_LOG2 = 10
) (
  input  logic              sample_clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] ad_data,
  input  logic              start,
  input  logic              continuous,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic              busy,
  output logic              frame_done,
  output logic [15:0]       drop_cnt
);

  localparam int FFT_LEN = 1 << LEN_LOG2;
  localparam logic [LEN_LOG2-1:0] LAST_ADDR = {LEN_LOG2{1'b1}};

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

  state_t              state;
  logic [LEN_LOG2-1:0] wr_addr;
  logic [LEN_LOG2-1:0] rd_addr;
  logic                started;
  logic [DATA_W-1:0]   wr_data;
  logic                wr_en;
  logic [DATA_W-1:0]   mem [FFT_LEN];

  function automatic logic [DATA_W-1:0] conv_sample(input logic [DATA_W-1:0] s);
`ifdef OFFSET_BIN_CONV_EN
    return {~s[DATA_W-1], s[DATA_W-2:0]};
`else
    return s;
`endif
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  // Capture stage: one RAM write per FILL cycle, no gaps
  assign wr_en   = (state == FILL);
  assign wr_data = conv_sample(ad_data);

  always_ff @(posedge sample_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Control and output stage; m_tdata is the RAM read register, so it only reloads on an empty or accepted beat
  always_ff @(posedge sample_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_addr    <= '0;
      rd_addr    <= '0;
      started    <= 1'b0;
      m_tdata    <= '0;
      m_tvalid   <= 1'b0;
      m_tlast    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      frame_done <= 1'b0;
      if (state == DRAIN || (state == IDLE && started))
        drop_cnt <= sat_inc(drop_cnt);

      case (state)
        IDLE: begin
          if (start) begin
            state   <= FILL;
            busy    <= 1'b1;
            started <= 1'b1;
            wr_addr <= '0;
          end
        end
        FILL: begin
          wr_addr <= wr_addr + 1'b1;
          if (wr_addr == LAST_ADDR) begin
            state   <= DRAIN;
            rd_addr <= '0;
          end
        end
        DRAIN: begin
          if (m_tvalid && m_tready && m_tlast) begin
            m_tvalid   <= 1'b0;
            m_tlast    <= 1'b0;
            frame_done <= 1'b1;
            if (continuous) begin
              state <= FILL;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (!m_tvalid || m_tready) begin
            m_tdata  <= mem[rd_addr];
            m_tvalid <= 1'b1;
            m_tlast  <= (rd_addr == LAST_ADDR);
            rd_addr  <= rd_addr + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_loader.sv
// Directed bench for fft_frame_loader with an 8-sample frame.
module tb_fft_frame_loader;
  localparam int DATA_W   = 16;
  localparam int LEN_LOG2 = 3;
  localparam int N        = 8;

  logic              sample_clk = 1'b0;
  logic              rst_n      = 1'b0;
  logic [DATA_W-1:0] ad_data    = '0;
  logic              start      = 1'b0;
  logic              continuous = 1'b0;
  logic              m_tready   = 1'b0;
  logic [DATA_W-1:0] m_tdata;
  logic              m_tvalid;
  logic              m_tlast;
  logic              busy;
  logic              frame_done;
  logic [15:0]       drop_cnt;

  int checks   = 0;
  int failures = 0;
  logic [15:0] din [N];
  logic [15:0] got [N];
  bit aborted;

  always #5 sample_clk = ~sample_clk;

  fft_frame_loader #(.DATA_W(DATA_W), .LEN_LOG2(LEN_LOG2)) dut (
    .sample_clk(sample_clk), .rst_n(rst_n), .ad_data(ad_data), .start(start),
    .continuous(continuous), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast), .busy(busy), .frame_done(frame_done), .drop_cnt(drop_cnt)
  );

  function automatic logic [15:0] model(input logic [15:0] s);
`ifdef OFFSET_BIN_CONV_EN
    return {~s[15], s[14:0]};
`else
    return s;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge sample_clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; continuous = 1'b0; m_tready = 1'b0; ad_data = '0;
    repeat (2) cycle();
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic set_ramp(input logic [15:0] b);
    for (int i = 0; i < N; i++) din[i] = b + 16'(i);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  // Presents din[0..N-1] on consecutive FILL cycles; returns in the first DRAIN cycle
  task automatic fill(input int start_at);
    for (int i = 0; i < N; i++) begin
      ad_data = din[i];
      start   = (i == start_at);
      cycle();
    end
    start = 1'b0;
  endtask

  task automatic prime_and_first();
    chk("prime_tvalid_low", m_tvalid, 0);
    cycle();
    chk("first_tvalid", m_tvalid, 1);
  endtask

  // Consumes a frame with the 4-cycle ready pattern; returns in the cycle after the last beat
  task automatic drain(input logic [3:0] pat, input int start_at, input int abort_at,
                       output bit ab);
    int idx = 0;
    int k = 0;
    bit hold = 1'b0;
    logic [15:0] held = '0;
    ab = 1'b0;
    while (idx < N && k < 64) begin
      if (hold) chk("stall_stable", {m_tvalid, m_tdata}, {1'b1, held});
      m_tready = pat[k % 4];
      start    = (k == start_at);
      if (m_tvalid && idx == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("abort_tdata", m_tdata, 0);
        chk("abort_tvalid", m_tvalid, 0);
        chk("abort_tlast", m_tlast, 0);
        chk("abort_busy", busy, 0);
        chk("abort_drop", drop_cnt, 0);
        start = 1'b0;
        ab = 1'b1;
        return;
      end
      hold = m_tvalid && !m_tready;
      held = m_tdata;
      if (m_tvalid && m_tready) begin
        got[idx] = m_tdata;
        chk("beat_data", m_tdata, model(din[idx]));
        chk("beat_last", m_tlast, (idx == N - 1));
        idx++;
      end
      cycle();
      k++;
    end
    start = 1'b0;
    chk("drain_beats", idx, N);
  endtask

  task automatic end_to_idle();
    chk("frame_done_pulse", frame_done, 1);
    chk("tvalid_after_last", m_tvalid, 0);
    cycle();
    chk("frame_done_cleared", frame_done, 0);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    // Reset state, and IDLE before any start must not count drops
    do_reset();
    chk("rst_tdata", m_tdata, 0);
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tlast", m_tlast, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_drop", drop_cnt, 0);
    continuous = 1'b1;
    cycle();
    chk("continuous_no_start", busy, 0);
    continuous = 1'b0;

    // Scenario 1: single shot, full-rate ready
    set_ramp(16'd1);
    m_tready = 1'b1;
    pulse_start();
    chk("busy_fill", busy, 1);
    fill(-1);
    prime_and_first();
    drain(4'b1111, -1, -1, aborted);
    end_to_idle();

    // Scenario 2: ready toggled 1,0,0,1
    set_ramp(16'd1);
    pulse_start();
    fill(-1);
    prime_and_first();
    drain(4'b1001, -1, -1, aborted);
    end_to_idle();

    // Scenario 3: continuous frames, drop counting
    do_reset();
    continuous = 1'b1;
    m_tready = 1'b1;
    set_ramp(16'd1);
    pulse_start();
    fill(-1);
    prime_and_first();
    drain(4'b1111, -1, -1, aborted);
    chk("cont_frame_done", frame_done, 1);
    chk("cont_busy", busy, 1);
    chk("cont_drop_f1", drop_cnt, 9);
    set_ramp(16'd9);
    fill(-1);
    continuous = 1'b0;
    prime_and_first();
    drain(4'b1111, -1, -1, aborted);
    chk("cont_drop_f2", drop_cnt, 18);
    end_to_idle();
    chk("idle_counts_drop", drop_cnt, 19);

    // Scenario 4: start re-pulsed during FILL and DRAIN
    set_ramp(16'd1);
    pulse_start();
    fill(3);
    prime_and_first();
    drain(4'b1111, 2, -1, aborted);
    end_to_idle();

    // Scenario 5: reset at beat 4, then a clean frame
    set_ramp(16'h0040);
    pulse_start();
    fill(-1);
    prime_and_first();
    drain(4'b1111, -1, 3, aborted);
    chk("abort_reached", aborted, 1);
    cycle();
    rst_n = 1'b1;
    cycle();
    chk("post_abort_idle", busy, 0);
    set_ramp(16'h0050);
    pulse_start();
    fill(-1);
    prime_and_first();
    drain(4'b1111, -1, -1, aborted);
    end_to_idle();

    // Scenario 6: MSB handling on the conversion corner values
    do_reset();
    m_tready = 1'b1;
    din[0] = 16'h8000; din[1] = 16'h0000; din[2] = 16'hFFFF; din[3] = 16'h0001;
    din[4] = 16'h7FFF; din[5] = 16'h8001; din[6] = 16'h1234; din[7] = 16'hFFFE;
    pulse_start();
    fill(-1);
    prime_and_first();
    drain(4'b1111, -1, -1, aborted);
    end_to_idle();
`ifdef OFFSET_BIN_CONV_EN
    chk("conv_8000", got[0], 16'h0000);
    chk("conv_0000", got[1], 16'h8000);
    chk("conv_ffff", got[2], 16'h7FFF);
`else
    chk("raw_8000", got[0], 16'h8000);
    chk("raw_0000", got[1], 16'h0000);
    chk("raw_ffff", got[2], 16'hFFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
